// File: rtl/mmu_feeder_if.sv
// mmu_feeder_if: handshake, weight and data buses between a tile source, the feeder and the systolic array.
// Optional: MMU_FEEDER_ROWCNT_EN adds the row_cnt status bus.
`default_nettype none

interface mmu_feeder_if #(
    parameter int BIT_WIDTH = 8,
    parameter int SIZE      = 4
);
    logic                 wt_valid;
    logic                 wt_ready;
    logic [BIT_WIDTH-1:0] wt_row   [SIZE-1:0];
    logic                 data_valid;
    logic                 data_ready;
    logic [BIT_WIDTH-1:0] data_row [SIZE-1:0];
    logic                 data_last;
    logic                 control;
    logic [BIT_WIDTH-1:0] wt_arr   [SIZE-1:0];
    logic [BIT_WIDTH-1:0] data_arr [SIZE-1:0];
    logic                 busy;
    logic                 drain_done;
`ifdef MMU_FEEDER_ROWCNT_EN
    logic [15:0]          row_cnt;
`endif

    modport master (
        output wt_valid, wt_row, data_valid, data_row, data_last,
        input  wt_ready, data_ready, control, wt_arr, data_arr, busy, drain_done
`ifdef MMU_FEEDER_ROWCNT_EN
        , input row_cnt
`endif
    );

    modport slave (
        input  wt_valid, wt_row, data_valid, data_row, data_last,
        output wt_ready, data_ready, control, wt_arr, data_arr, busy, drain_done
`ifdef MMU_FEEDER_ROWCNT_EN
        , output row_cnt
`endif
    );
endinterface

`default_nettype wire

// File: rtl/mmu_feeder.sv
// mmu_feeder: loads a weight tile into the systolic array, then streams diagonally skewed data and drains it.
// Optional: MMU_FEEDER_ROWCNT_EN counts accepted data beats per tile on row_cnt.
`default_nettype none

module mmu_feeder #(
    parameter int BIT_WIDTH = 8,
    parameter int SIZE      = 4
) (
    input  logic        clk,
    input  logic        reset,
    mmu_feeder_if.slave bus
);
    localparam int              CW       = $clog2(2*SIZE+1);
    localparam logic [CW-1:0]   WT_LAST  = CW'(SIZE-1);
    localparam logic [CW-1:0]   DRN_LAST = CW'(2*SIZE-1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_WT = 2'd1,
        STREAM  = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        wt_cnt_q;
    logic [CW-1:0]        drn_cnt_q;
    logic                 control_q;
    logic                 busy_q;
    logic                 drain_done_q;
    logic [BIT_WIDTH-1:0] wt_arr_q [SIZE-1:0];
    logic [BIT_WIDTH-1:0] col_d    [SIZE-1:0];
`ifdef MMU_FEEDER_ROWCNT_EN
    logic [15:0]          row_cnt_q;
`endif

    logic wt_ready;
    logic data_ready;
    logic wt_acc;
    logic data_acc;

    assign wt_ready   = (state_q == IDLE) || (state_q == LOAD_WT);
    assign data_ready = (state_q == STREAM);
    assign wt_acc     = bus.wt_valid && wt_ready;
    assign data_acc   = bus.data_valid && data_ready;

    assign bus.wt_ready   = wt_ready;
    assign bus.data_ready = data_ready;
    assign bus.control    = control_q;
    assign bus.wt_arr     = wt_arr_q;
    assign bus.busy       = busy_q;
    assign bus.drain_done = drain_done_q;
`ifdef MMU_FEEDER_ROWCNT_EN
    assign bus.row_cnt    = row_cnt_q;
`endif

    // Column entering the skew network: accepted vector, or a zero bubble
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            col_d[i] = data_acc ? bus.data_row[i] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wt_cnt_q     <= '0;
            drn_cnt_q    <= '0;
            control_q    <= 1'b0;
            busy_q       <= 1'b0;
            drain_done_q <= 1'b0;
            for (int i = 0; i < SIZE; i++) wt_arr_q[i] <= '0;
`ifdef MMU_FEEDER_ROWCNT_EN
            row_cnt_q    <= '0;
`endif
        end else begin
            control_q    <= wt_acc;
            drain_done_q <= 1'b0;
            for (int i = 0; i < SIZE; i++) wt_arr_q[i] <= wt_acc ? bus.wt_row[i] : '0;
            case (state_q)
                IDLE: begin
                    if (wt_acc) begin
                        state_q  <= (SIZE == 1) ? STREAM : LOAD_WT;
                        wt_cnt_q <= CW'(1);
                        busy_q   <= 1'b1;
`ifdef MMU_FEEDER_ROWCNT_EN
                        row_cnt_q <= '0;
`endif
                    end
                end
                LOAD_WT: begin
                    if (wt_acc) begin
                        if (wt_cnt_q == WT_LAST) begin
                            state_q  <= STREAM;
                            wt_cnt_q <= '0;
                        end else begin
                            wt_cnt_q <= wt_cnt_q + CW'(1);
                        end
                    end
                end
                STREAM: begin
                    if (data_acc) begin
`ifdef MMU_FEEDER_ROWCNT_EN
                        if (row_cnt_q != 16'hFFFF) row_cnt_q <= row_cnt_q + 16'd1;
`endif
                        if (bus.data_last) begin
                            state_q   <= DRAIN;
                            drn_cnt_q <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // Skew flush plus accumulator chain and the array's output register
                    if (drn_cnt_q == DRN_LAST) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        drain_done_q <= 1'b1;
                        drn_cnt_q    <= '0;
                    end else begin
                        drn_cnt_q <= drn_cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
        if (gi == 0) begin : g_tap0
            logic [BIT_WIDTH-1:0] out_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) out_q <= '0;
                else       out_q <= col_d[0];
            end
            assign bus.data_arr[0] = out_q;
        end else begin : g_dly
            // Row gi sits gi cycles behind row 0 to form the diagonal wavefront
            logic [BIT_WIDTH-1:0] dly_q [gi];
            logic [BIT_WIDTH-1:0] out_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < gi; k++) dly_q[k] <= '0;
                    out_q <= '0;
                end else begin
                    dly_q[0] <= col_d[gi];
                    for (int k = 1; k < gi; k++) dly_q[k] <= dly_q[k-1];
                    out_q <= dly_q[gi-1];
                end
            end
            assign bus.data_arr[gi] = out_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mmu_feeder.sv
// tb_mmu_feeder: random and directed tiles checked every cycle against a cycle-indexed history model.
`default_nettype none

module tb_mmu_feeder;
    localparam int BW = 8;
    localparam int S  = 4;
    localparam int N  = 4096;

    typedef logic [BW-1:0] vec_t [S-1:0];

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mmu_feeder_if #(.BIT_WIDTH(BW), .SIZE(S)) bus ();
    mmu_feeder #(.BIT_WIDTH(BW), .SIZE(S)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int hist_start = 0;
    int last_cyc = -1000;
    int mode = 0;      // 0 idle, 1 loading weights, 2 streaming, 3 draining
    int beats = 0;
    bit   wacc_h [N];
    vec_t wrow_h [N];
    bit   dacc_h [N];
    vec_t drow_h [N];
`ifdef MMU_FEEDER_ROWCNT_EN
    int rows_model = 0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit w_acc_at(input int c);
        return (c >= hist_start) && (c >= 0) && wacc_h[c];
    endfunction

    function automatic logic [BW-1:0] exp_wt(input int i);
        if (w_acc_at(cyc-1)) return wrow_h[cyc-1][i];
        return '0;
    endfunction

    function automatic logic [BW-1:0] exp_data(input int i);
        int c;
        c = cyc - 1 - i;
        if (c >= hist_start && c >= 0 && dacc_h[c]) return drow_h[c][i];
        return '0;
    endfunction

    function automatic vec_t mk(input int a, input int b, input int c, input int d);
        vec_t v;
        v[0] = BW'(a); v[1] = BW'(b); v[2] = BW'(c); v[3] = BW'(d);
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int i = 0; i < S; i++) v[i] = BW'($urandom);
        return v;
    endfunction

    // Called at a falling edge: check this cycle's outputs, drive this cycle's inputs, advance.
    task automatic step(input bit wv, input vec_t wr, input bit dv, input vec_t dr, input bit dl);
        bit wa, da;
        if (cyc >= N - 1) begin
            $display("FAIL cycle_budget cyc=%0d got=%0d exp<%0d", cyc, cyc, N - 1);
            $fatal(1, "cycle budget exhausted");
        end
        check_eq("busy", bus.busy, 32'(mode != 0));
        check_eq("wt_ready", bus.wt_ready, 32'(mode <= 1));
        check_eq("data_ready", bus.data_ready, 32'(mode == 2));
        check_eq("control", bus.control, 32'(w_acc_at(cyc-1)));
        for (int i = 0; i < S; i++) check_eq($sformatf("wt_arr%0d", i), bus.wt_arr[i], exp_wt(i));
        for (int i = 0; i < S; i++) check_eq($sformatf("data_arr%0d", i), bus.data_arr[i], exp_data(i));
        check_eq("drain_done", bus.drain_done, 32'(cyc == last_cyc + 2*S + 1));
`ifdef MMU_FEEDER_ROWCNT_EN
        check_eq("row_cnt", bus.row_cnt, rows_model);
`endif
        bus.wt_valid   = wv;
        bus.data_valid = dv;
        bus.data_last  = dl;
        for (int i = 0; i < S; i++) begin
            bus.wt_row[i]   = wr[i];
            bus.data_row[i] = dr[i];
        end
        wa = wv && (mode <= 1);
        da = dv && (mode == 2);
        wacc_h[cyc] = wa;
        wrow_h[cyc] = wr;
        dacc_h[cyc] = da;
        drow_h[cyc] = dr;
        case (mode)
            0: if (wa) begin
                beats = 1;
`ifdef MMU_FEEDER_ROWCNT_EN
                rows_model = 0;
`endif
                mode = (beats == S) ? 2 : 1;
            end
            1: if (wa) begin
                beats++;
                if (beats == S) mode = 2;
            end
            2: if (da) begin
`ifdef MMU_FEEDER_ROWCNT_EN
                if (rows_model < 65535) rows_model++;
`endif
                if (dl) begin
                    mode = 3;
                    last_cyc = cyc;
                end
            end
            default: if (cyc == last_cyc + 2*S) mode = 0;
        endcase
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_control", bus.control, 0);
        check_eq("rst_drain_done", bus.drain_done, 0);
        check_eq("rst_wt_ready", bus.wt_ready, 1);
        check_eq("rst_data_ready", bus.data_ready, 0);
        for (int i = 0; i < S; i++) begin
            check_eq($sformatf("rst_wt_arr%0d", i), bus.wt_arr[i], 0);
            check_eq($sformatf("rst_data_arr%0d", i), bus.data_arr[i], 0);
        end
`ifdef MMU_FEEDER_ROWCNT_EN
        check_eq("rst_row_cnt", bus.row_cnt, 0);
        rows_model = 0;
`endif
        bus.wt_valid   = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset      = 1'b0;
        mode       = 0;
        beats      = 0;
        last_cyc   = -1000;
        hist_start = cyc;
    endtask

    initial begin
        vec_t z;
        z = mk(0, 0, 0, 0);
        reset = 1'b1;
        bus.wt_valid = 1'b0; bus.data_valid = 1'b0; bus.data_last = 1'b0;
        for (int i = 0; i < S; i++) begin bus.wt_row[i] = '0; bus.data_row[i] = '0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        hist_start = cyc;
        step(0, z, 0, z, 0);

        // Back-to-back weight tile, two vectors, full drain
        step(1, mk(1,1,1,1), 0, z, 0);
        step(1, mk(2,2,2,2), 1, mk(9,9,9,9), 0);
        step(1, mk(3,3,3,3), 0, z, 0);
        step(1, mk(4,4,4,4), 0, z, 0);
        step(1, mk(7,7,7,7), 1, mk(1,2,3,4), 0);
        step(0, z, 1, mk(5,6,7,8), 1);
        for (int k = 0; k < 2*S + 1 && mode != 0; k++) step(0, z, 0, z, 0);

        // Weight gap, bubble between vectors, back-to-back tile on drain_done
        step(1, mk(1,1,1,1), 0, z, 0);
        step(1, mk(2,2,2,2), 0, z, 0);
        step(0, mk(8,8,8,8), 0, z, 0);
        step(1, mk(3,3,3,3), 0, z, 0);
        step(1, mk(4,4,4,4), 0, z, 0);
        step(0, z, 1, mk(9,10,11,12), 0);
        step(0, z, 0, mk(99,99,99,99), 0);
        step(0, z, 1, mk(13,14,15,16), 0);
        step(0, z, 1, mk(17,18,19,20), 1);
        for (int k = 0; k < 2*S + 1 && mode != 0; k++) step(0, z, 0, z, 0);
        step(1, mk(21,22,23,24), 0, z, 0);
        for (int k = 0; k < S - 1; k++) step(1, rnd_vec(), 0, z, 0);

        // Reset while streaming
        step(0, z, 1, mk(31,32,33,34), 0);
        step(0, z, 1, mk(35,36,37,38), 0);
        async_reset();
        for (int k = 0; k < 2*S + 2; k++) step(0, z, 0, z, 0);

        // Randomized tiles with occasional mid-operation reset
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) async_reset();
            else step($urandom_range(0, 3) != 0, rnd_vec(),
                      $urandom_range(0, 3) != 0, rnd_vec(),
                      $urandom_range(0, 4) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
